// File: rtl/dmem_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// dmem_dump_reader_pkg
// Shared widths, dump FSM state encodings and small address helpers for the
// data-BRAM dump reader.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN (adds the checksum trailer beat).
// -----------------------------------------------------------------------------
package dmem_dump_reader_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DBG_ADDR_W = 12;
    localparam int CNT_W      = 11;

    typedef enum logic [2:0] {
        DUMP_IDLE    = 3'd0,
        DUMP_ISSUE   = 3'd1,
        DUMP_WAIT    = 3'd2,
        DUMP_PRESENT = 3'd3,
        DUMP_FINISH  = 3'd4,
        DUMP_CHK     = 3'd5
    } dump_state_e;

    // Clears the two byte-offset bits so every BRAM access is word aligned.
    function automatic logic [DBG_ADDR_W-1:0] word_align(input logic [DBG_ADDR_W-1:0] a);
        return a & ~DBG_ADDR_W'(3);
    endfunction

    // Next word address; wraps naturally modulo 2**DBG_ADDR_W.
    function automatic logic [DBG_ADDR_W-1:0] next_word_addr(input logic [DBG_ADDR_W-1:0] a);
        return a + DBG_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/dmem_dump_reader_if.sv
// -----------------------------------------------------------------------------
// dmem_dump_reader_if
// Valid/ready dump stream: one beat per memory word with its byte address.
//   valid : beat valid (master -> slave)
//   ready : beat accepted when valid & ready (slave -> master)
//   data  : dumped word
//   addr  : byte address of data (0 on the checksum trailer)
//   last  : final beat of the dump
// -----------------------------------------------------------------------------
interface dmem_dump_reader_if;
    import dmem_dump_reader_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [DBG_ADDR_W-1:0] addr;
    logic                  last;

    modport master (output valid, output data, output addr, output last, input ready);
    modport slave  (input valid, input data, input addr, input last, output ready);

endinterface

// File: rtl/dmem_dump_reader_out_reg.sv
// -----------------------------------------------------------------------------
// dmem_dump_reader_out_reg
// Dump output holding register. A load captures data/addr/last and raises
// valid; the beat is then held unchanged until the downstream handshake,
// which drops valid. A load in the same cycle as a handshake wins, so
// back-to-back beats need no bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_i              capture data_i/addr_i/last_i and present a beat
//   data_i/addr_i/last_i beat contents to capture
//   ready_i             downstream ready
//   valid_o/data_o/addr_o/last_o  registered beat outputs
// -----------------------------------------------------------------------------
module dmem_dump_reader_out_reg
    import dmem_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DBG_ADDR_W-1:0] addr_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DBG_ADDR_W-1:0] addr_o,
    output logic                  last_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DBG_ADDR_W-1:0] addr_q;
    logic                  last_q;

    // Beat holding register: load, hold while stalled, clear on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            addr_q  <= addr_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign last_o  = last_q;

endmodule

// File: rtl/dmem_dump_reader.sv
// -----------------------------------------------------------------------------
// dmem_dump_reader
// Reads a window of data BRAM through its debug read port after execution
// and streams each word out with its byte address. The core is frozen
// (halt_req_o) for the whole dump.
// Parameter RD_LAT: debug port read latency, 0 (combinational) or 1 (registered).
// Optional feature macro DMEM_DUMP_CHECKSUM_EN: appends a trailer beat carrying
// the 32-bit sum of all dumped words (addr 0, last 1); data beats then carry last=0.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (aborts a dump, no done)
//   start_i         one-cycle request, sampled only when idle
//   base_addr_i     first byte address (bits [1:0] ignored)
//   word_cnt_i      number of words, 0 gives an immediate done with no beats
//   busy_o          high from accepted start through the done cycle
//   done_o          one-cycle completion pulse
//   halt_req_o      equals busy_o, stalls the core
//   debug_addr_o    word address to the BRAM debug port
//   debug_data_i    BRAM debug read data
//   m_if            dump stream (master)
// -----------------------------------------------------------------------------
module dmem_dump_reader
    import dmem_dump_reader_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DBG_ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]      word_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  halt_req_o,
    output logic [DBG_ADDR_W-1:0] debug_addr_o,
    input  logic [DATA_WIDTH-1:0] debug_data_i,
    dmem_dump_reader_if.master    m_if
);

    localparam bit RD_COMB = (RD_LAT == 0);

    dump_state_e           state_q, state_d;
    logic [DBG_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic                  hs_s;
    logic                  last_word_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] ld_data_s;
    logic [DBG_ADDR_W-1:0] ld_addr_s;
    logic                  ld_last_s;

    assign hs_s        = m_if.valid & m_if.ready;
    assign last_word_s = (remain_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DUMP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DUMP_IDLE: begin
                if (start_i) begin
                    state_d = (word_cnt_i == CNT_W'(0)) ? DUMP_FINISH : DUMP_ISSUE;
                end else begin
                    state_d = DUMP_IDLE;
                end
            end
            DUMP_ISSUE:   state_d = RD_COMB ? DUMP_PRESENT : DUMP_WAIT;
            DUMP_WAIT:    state_d = DUMP_PRESENT;
            DUMP_PRESENT: begin
                if (hs_s) begin
                    if (last_word_s) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_d = DUMP_CHK;
`else
                        state_d = DUMP_FINISH;
`endif
                    end else begin
                        state_d = DUMP_ISSUE;
                    end
                end else begin
                    state_d = DUMP_PRESENT;
                end
            end
            DUMP_CHK: begin
                if (hs_s) begin
                    state_d = DUMP_FINISH;
                end else begin
                    state_d = DUMP_CHK;
                end
            end
            DUMP_FINISH:  state_d = DUMP_IDLE;
            default:      state_d = DUMP_IDLE;
        endcase
    end

    // Output / datapath next values: address and remain counters, beat loads.
    always_comb begin
        addr_d    = addr_q;
        remain_d  = remain_q;
        load_s    = 1'b0;
        ld_data_s = debug_data_i;
        ld_addr_s = addr_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
        sum_d     = sum_q;
        ld_last_s = 1'b0;
`else
        ld_last_s = last_word_s;
`endif
        case (state_q)
            DUMP_IDLE: begin
                if (start_i) begin
                    addr_d   = word_align(base_addr_i);
                    remain_d = word_cnt_i;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end else begin
                    addr_d   = addr_q;
                end
            end
            DUMP_ISSUE, DUMP_WAIT: begin
                // Read data is valid in ISSUE for a combinational port, in WAIT otherwise.
                if ((state_q == DUMP_WAIT) || RD_COMB) begin
                    load_s = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d  = sum_q + debug_data_i;
`endif
                end else begin
                    load_s = 1'b0;
                end
            end
            DUMP_PRESENT: begin
                if (hs_s) begin
                    addr_d   = next_word_addr(addr_q);
                    remain_d = remain_q - CNT_W'(1);
`ifdef DMEM_DUMP_CHECKSUM_EN
                    // Trailer is loaded on the last data handshake so it follows with no gap.
                    if (last_word_s) begin
                        load_s    = 1'b1;
                        ld_data_s = sum_q;
                        ld_addr_s = '0;
                        ld_last_s = 1'b1;
                    end else begin
                        load_s    = 1'b0;
                    end
`endif
                end else begin
                    addr_d = addr_q;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
        busy_d = (state_d != DUMP_IDLE);
        done_d = (state_d == DUMP_FINISH);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    dmem_dump_reader_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_s),
        .data_i  (ld_data_s),
        .addr_i  (ld_addr_s),
        .last_i  (ld_last_s),
        .ready_i (m_if.ready),
        .valid_o (m_if.valid),
        .data_o  (m_if.data),
        .addr_o  (m_if.addr),
        .last_o  (m_if.last)
    );

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign halt_req_o   = busy_q;
    assign debug_addr_o = addr_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_dmem_dump_reader
// Randomized bench for dmem_dump_reader with a registered (RD_LAT=1) BRAM
// model. Expected beats are built from the memory array by address
// arithmetic; the optional checksum trailer follows DMEM_DUMP_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_dmem_dump_reader;
    import dmem_dump_reader_pkg::*;

`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start_i;
    logic [DBG_ADDR_W-1:0] base_addr_i;
    logic [CNT_W-1:0]      word_cnt_i;
    logic                  busy_o, done_o, halt_req_o;
    logic [DBG_ADDR_W-1:0] debug_addr_o;
    logic [DATA_WIDTH-1:0] debug_data_i;

    dmem_dump_reader_if m_if ();

    dmem_dump_reader #(.RD_LAT(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .word_cnt_i   (word_cnt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .halt_req_o   (halt_req_o),
        .debug_addr_o (debug_addr_o),
        .debug_data_i (debug_data_i),
        .m_if         (m_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    // Registered BRAM debug port.
    always @(posedge clk) debug_data_i <= mem[debug_addr_o[11:2]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {last, addr, data}
    logic [44:0] exp_q [$];

    task automatic build_expect(input logic [11:0] base, input int cnt);
        logic [11:0] a;
        logic [31:0] sum;
        exp_q.delete();
        a   = base & 12'hFFC;
        sum = 32'd0;
        for (int i = 0; i < cnt; i++) begin
            sum = sum + mem[a >> 2];
            exp_q.push_back({(!CHK_EN && (i == cnt - 1)), a, mem[a >> 2]});
            a = a + 12'd4;
        end
        if (CHK_EN && cnt > 0) exp_q.push_back({1'b1, 12'h000, sum});
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc / 3) % 2) == 1;
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic run_dump(input logic [11:0] base, input int cnt, input int mode, input bit strays);
        int          cyc;
        int          busy_cyc;
        bit          finished;
        logic [44:0] e;
        build_expect(base, cnt);
        cyc = 0; busy_cyc = 0; finished = 1'b0;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        word_cnt_i  = CNT_W'(cnt);
        m_if.ready  = pick_ready(mode, 0);
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            check_eq("busy", busy_o, 1);
            check_eq("halt_req", halt_req_o, 1);
            if (busy_o) busy_cyc++;
            if (done_o) begin
                finished = 1'b1;
                check_eq("beats_left", exp_q.size(), 0);
                check_eq("valid_at_done", m_if.valid, 0);
            end
            if (m_if.valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", m_if.valid, 0);
                end else begin
                    e = exp_q[0];
                    check_eq("m_data", m_if.data, e[31:0]);
                    check_eq("m_addr", m_if.addr, e[43:32]);
                    check_eq("m_last", m_if.last, e[44]);
                end
            end
            m_if.ready = pick_ready(mode, cyc);
            if (m_if.valid && m_if.ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (strays && !finished) start_i = ($urandom_range(0, 5) == 0);
        end
        check_eq("done_seen", finished, 1);
        if (mode == 0 && finished)
            check_eq("busy_cycles", busy_cyc,
                     (cnt == 0) ? 1 : (3 * cnt + 1 + (CHK_EN ? 1 : 0)));
        start_i = 1'b0;
        @(negedge clk);
        check_eq("busy_after", busy_o, 0);
        check_eq("done_after", done_o, 0);
        check_eq("valid_after", m_if.valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_halt"}, halt_req_o, 0);
        check_eq({tag, "_valid"}, m_if.valid, 0);
        check_eq({tag, "_last"}, m_if.last, 0);
        check_eq({tag, "_data"}, m_if.data, 0);
        check_eq({tag, "_addr"}, m_if.addr, 0);
        check_eq({tag, "_dbgaddr"}, debug_addr_o, 0);
    endtask

    task automatic reset_mid_dump();
        bit found;
        found = 1'b0;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 12'h000; word_cnt_i = CNT_W'(3); m_if.ready = 1'b1;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (m_if.valid && m_if.addr == 12'h004) found = 1'b1;
        end
        check_eq("rst_trigger", found, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_done_in_rst", done_o, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("no_done_after_rst", done_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; word_cnt_i = '0; m_if.ready = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_dump(12'h000, 3, 0, 1'b0);      // basic, ready held high
        run_dump(12'h000, 3, 1, 1'b0);      // ready toggling every 3 cycles
        run_dump(12'h000, 0, 0, 1'b0);      // zero-length dump
        run_dump(12'hFFC, 2, 0, 1'b0);      // address wrap
        run_dump(12'h006, 2, 0, 1'b0);      // unaligned base
        reset_mid_dump();
        run_dump(12'h000, 3, 0, 1'b0);      // restart after reset

        for (int t = 0; t < 25; t++)
            run_dump(12'($urandom_range(0, 4095)), $urandom_range(0, 12),
                     $urandom_range(0, 2), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
